dma_axi_simple_core_write: RTL and testbench

- Write half of the simple AXI DMA; the stage downstream of the DMA read core.
- Pops beats that the read core pushed into the shared data FIFO and writes them to DMA_DST through the AXI AW/W/B channels.
- Splits the transfer exactly as the read core splits DMA_SRC, so FIFO beats line up with write bursts byte-lane for byte-lane.
- Raises DMA_DONE after the last B response.

---
 rtl/dma_axi_simple_core_write.sv | 247 ++++++++++++++++++++++++
 tb/tb_dma_axi_simple_core_write.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_simple_core_write.sv
// rtl/dma_axi_simple_core_write.sv - AXI write half of the simple DMA: FIFO beats to DMA_DST via AW/W/B
`timescale 1ns/1ps
module dma_axi_simple_core_write #(
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int AXI_WIDTH_DS  = AXI_WIDTH_DA/8,
  parameter int AXI_WIDTH_DSB = $clog2(AXI_WIDTH_DS),
  parameter int FIFO_WIDTH    = AXI_WIDTH_DS+AXI_WIDTH_DA,
  parameter int FIFO_AW       = 4,
  parameter int FIFO_DEPTH    = 1<<FIFO_AW
) (
  input  logic                    ARESETn,
  input  logic                    ACLK,
  output logic [AXI_WIDTH_ID-1:0] M_AWID,
  output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [AXI_WIDTH_DA-1:0] M_WDATA,
  output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
  output logic                    M_WLAST,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [AXI_WIDTH_ID-1:0] M_BID,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  input  logic                    DMA_EN,
  input  logic                    DMA_GO,
  input  logic [31:0]             DMA_DST,
  input  logic [31:0]             DMA_SRC,
  input  logic [15:0]             DMA_BNUM,
  input  logic [7:0]              DMA_CHUNK,
  output logic                    DMA_BUSY,
  output logic                    DMA_DONE,
  output logic                    DMA_ERR,
  output logic                    fifo_rd_rdy,
  input  logic                    fifo_rd_vld,
  input  logic [FIFO_WIDTH-1:0]   fifo_rd_dat
);

  typedef enum logic [2:0] {C_READY, C_MISALIGN, C_ALIGN, C_WRITE, C_WRITE_DONE} c_state_e;
  typedef enum logic [2:0] {A_IDLE, A_AW, A_W, A_B, A_DONE} a_state_e;

  localparam logic [15:0] DS16    = 16'(AXI_WIDTH_DS);
  localparam logic [15:0] DEPTH16 = 16'(FIFO_DEPTH);

  c_state_e c_state_q, c_state_d;
  a_state_e a_state_q, a_state_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d, awaddr_q, awaddr_d;
  logic [15:0] rem_q, rem_d, chunk_q, chunk_d, inc_q, inc_d;
  logic [8:0]  len_q, len_d, cnt_q, cnt_d, blen_q, blen_d;
  logic size_full_q, size_full_d, go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [AXI_WIDTH_ID-1:0] cid_q, cid_d, awid_q, awid_d;
  logic [7:0] awlen_q, awlen_d;
  logic [2:0] awsize_q, awsize_d;
  logic awvalid_q, awvalid_d, bdone_q, bdone_d;
  logic [AXI_WIDTH_DS-1:0] wstrb_q, wstrb_d;

  logic [AXI_WIDTH_DSB-1:0] addr_lo;
  logic [15:0] head16, chunk_beats, chunk_calc, rem_beats;
  logic bresp_err, w_st;
  logic unused_bits;

  assign addr_lo     = addr_q[AXI_WIDTH_DSB-1:0];
  assign head16      = DS16 - 16'(addr_lo);
  assign chunk_beats = 16'(DMA_CHUNK >> AXI_WIDTH_DSB);
  assign rem_beats   = rem_q >> AXI_WIDTH_DSB;
  assign bresp_err   = (a_state_q == A_B) && M_BVALID && (M_BRESP != 2'b00);
  assign w_st        = (a_state_q == A_W);
  assign unused_bits = ^{DMA_SRC[31:AXI_WIDTH_DSB], M_BID, fifo_rd_dat[FIFO_WIDTH-1:AXI_WIDTH_DA]};

  always_comb begin
    chunk_calc = DS16;
    if (DMA_BNUM <= DS16)
      chunk_calc = DMA_BNUM;
    else if ({8'd0, DMA_CHUNK} > DS16)
      chunk_calc = ((chunk_beats < DEPTH16) ? chunk_beats : DEPTH16) << AXI_WIDTH_DSB;
  end

  // Control FSM: carves the transfer into bursts the same way the read core does.
  always_comb begin
    c_state_d = c_state_q; addr_d = addr_q; rem_d = rem_q; chunk_d = chunk_q;
    size_full_d = size_full_q; len_d = len_q; inc_d = inc_q; go_d = go_q;
    busy_d = busy_q; done_d = done_q; err_d = err_q | bresp_err;
    case (c_state_q)
      C_READY: begin
        if (!DMA_GO) begin
          done_d = 1'b0;
        end else if (!done_q && DMA_BNUM != 16'd0) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          addr_d  = AXI_WIDTH_AD'(DMA_DST);
          rem_d   = DMA_BNUM;
          chunk_d = chunk_calc;
          if (DMA_DST[AXI_WIDTH_DSB-1:0] != DMA_SRC[AXI_WIDTH_DSB-1:0]) begin
            err_d  = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else if (DMA_DST[AXI_WIDTH_DSB-1:0] != '0) begin
            c_state_d = C_MISALIGN;
          end else begin
            c_state_d = C_ALIGN;
          end
        end
      end
      C_MISALIGN: begin
        go_d = 1'b1;
        len_d = 9'd1;
        c_state_d = C_WRITE;
        if (rem_q < head16) begin
          size_full_d = 1'b0;
          inc_d = 16'd1;
        end else begin
          size_full_d = 1'b1;
          inc_d = head16;
        end
      end
      C_ALIGN: begin
        go_d = 1'b1;
        c_state_d = C_WRITE;
        size_full_d = 1'b1;
        if (rem_q >= chunk_q) begin
          len_d = 9'(chunk_q >> AXI_WIDTH_DSB);
        end else if (rem_beats != 16'd0) begin
          len_d = 9'(rem_beats);
        end else begin
          size_full_d = 1'b0;
          len_d = 9'd1;
        end
        inc_d = size_full_d ? (16'(len_d) << AXI_WIDTH_DSB) : 16'(len_d);
      end
      C_WRITE: begin
        if (bdone_q) begin
          addr_d = addr_q + AXI_WIDTH_AD'(inc_q);
          rem_d  = rem_q - inc_q;
          go_d   = 1'b0;
          c_state_d = C_WRITE_DONE;
        end
      end
      C_WRITE_DONE: begin
        if (!bdone_q) begin
          if (rem_q != 16'd0) begin
            c_state_d = (addr_lo != '0) ? C_MISALIGN : C_ALIGN;
          end else begin
            done_d = 1'b1;
            busy_d = 1'b0;
            c_state_d = C_READY;
          end
        end
      end
      default: c_state_d = C_READY;
    endcase
    if (!DMA_EN) begin
      c_state_d = C_READY; addr_d = '0; rem_d = '0; chunk_d = '0; size_full_d = 1'b0;
      len_d = '0; inc_d = '0; go_d = 1'b0; busy_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
    end
  end

  // AXI FSM: one AW, len W beats, one B per go pulse.
  always_comb begin
    a_state_d = a_state_q; cid_d = cid_q; awid_d = awid_q; awaddr_d = awaddr_q;
    awlen_d = awlen_q; awsize_d = awsize_q; awvalid_d = awvalid_q; cnt_d = cnt_q;
    blen_d = blen_q; wstrb_d = wstrb_q; bdone_d = bdone_q;
    case (a_state_q)
      A_IDLE: begin
        if (go_q) begin
          cid_d     = cid_q + AXI_WIDTH_ID'(1);
          awid_d    = cid_q + AXI_WIDTH_ID'(1);
          awaddr_d  = addr_q;
          awlen_d   = len_q[7:0] - 8'd1;
          awsize_d  = size_full_q ? 3'(AXI_WIDTH_DSB) : 3'd0;
          awvalid_d = 1'b1;
          blen_d    = len_q;
          wstrb_d   = size_full_q ? ({AXI_WIDTH_DS{1'b1}} << addr_lo) : (AXI_WIDTH_DS'(1) << addr_lo);
          a_state_d = A_AW;
        end
      end
      A_AW: begin
        if (M_AWREADY) begin
          awvalid_d = 1'b0;
          cnt_d = 9'd1;
          a_state_d = A_W;
        end
      end
      A_W: begin
        if (fifo_rd_vld && M_WREADY) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == blen_q) a_state_d = A_B;
        end
      end
      A_B: begin
        if (M_BVALID) begin
          bdone_d = 1'b1;
          a_state_d = A_DONE;
        end
      end
      A_DONE: begin
        if (!go_q) begin
          bdone_d = 1'b0;
          a_state_d = A_IDLE;
        end
      end
      default: a_state_d = A_IDLE;
    endcase
    if (!DMA_EN) begin
      a_state_d = A_IDLE; cid_d = '0; awid_d = '0; awaddr_d = '0; awlen_d = '0; awsize_d = '0;
      awvalid_d = 1'b0; cnt_d = '0; blen_d = '0; wstrb_d = '0; bdone_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      c_state_q <= C_READY; addr_q <= '0; rem_q <= '0; chunk_q <= '0; size_full_q <= 1'b0;
      len_q <= '0; inc_q <= '0; go_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      a_state_q <= A_IDLE; cid_q <= '0; awid_q <= '0; awaddr_q <= '0; awlen_q <= '0;
      awsize_q <= '0; awvalid_q <= 1'b0; cnt_q <= '0; blen_q <= '0; wstrb_q <= '0; bdone_q <= 1'b0;
    end else begin
      c_state_q <= c_state_d; addr_q <= addr_d; rem_q <= rem_d; chunk_q <= chunk_d;
      size_full_q <= size_full_d; len_q <= len_d; inc_q <= inc_d; go_q <= go_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      a_state_q <= a_state_d; cid_q <= cid_d; awid_q <= awid_d; awaddr_q <= awaddr_d;
      awlen_q <= awlen_d; awsize_q <= awsize_d; awvalid_q <= awvalid_d; cnt_q <= cnt_d;
      blen_q <= blen_d; wstrb_q <= wstrb_d; bdone_q <= bdone_d;
    end
  end

  assign M_AWID      = awid_q;
  assign M_AWADDR    = awaddr_q;
  assign M_AWLEN     = awlen_q;
  assign M_AWSIZE    = awsize_q;
  assign M_AWBURST   = 2'b01;
  assign M_AWVALID   = awvalid_q;
  assign M_WDATA     = w_st ? fifo_rd_dat[AXI_WIDTH_DA-1:0] : '0;
  assign M_WSTRB     = wstrb_q;
  assign M_WLAST     = w_st && (cnt_q == blen_q);
  assign M_WVALID    = w_st && fifo_rd_vld;
  assign fifo_rd_rdy = w_st && M_WREADY;
  assign M_BREADY    = (a_state_q == A_B);
  assign DMA_BUSY    = busy_q;
  assign DMA_DONE    = done_q;
  assign DMA_ERR     = err_q;

endmodule

// File: tb/tb_dma_axi_simple_core_write.sv
// tb/tb_dma_axi_simple_core_write.sv - scoreboard bench for the DMA write core
`timescale 1ns/1ps
module tb_dma_axi_simple_core_write;
  localparam int DS = 4;

  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [3:0] M_AWID; logic [31:0] M_AWADDR; logic [7:0] M_AWLEN; logic [2:0] M_AWSIZE;
  logic [1:0] M_AWBURST; logic M_AWVALID, M_AWREADY = 1'b0;
  logic [31:0] M_WDATA; logic [3:0] M_WSTRB; logic M_WLAST, M_WVALID, M_WREADY = 1'b0;
  logic [3:0] M_BID = '0; logic [1:0] M_BRESP = '0; logic M_BVALID = 1'b0, M_BREADY;
  logic DMA_EN = 1'b1, DMA_GO = 1'b0;
  logic [31:0] DMA_DST = '0, DMA_SRC = '0; logic [15:0] DMA_BNUM = '0; logic [7:0] DMA_CHUNK = '0;
  logic DMA_BUSY, DMA_DONE, DMA_ERR, fifo_rd_rdy, fifo_rd_vld = 1'b0;
  logic [35:0] fifo_rd_dat = '0;

  always #5 ACLK = ~ACLK;

  dma_axi_simple_core_write dut (
    .ARESETn(ARESETn), .ACLK(ACLK),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .DMA_EN(DMA_EN), .DMA_GO(DMA_GO), .DMA_DST(DMA_DST), .DMA_SRC(DMA_SRC),
    .DMA_BNUM(DMA_BNUM), .DMA_CHUNK(DMA_CHUNK), .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE),
    .DMA_ERR(DMA_ERR), .fifo_rd_rdy(fifo_rd_rdy), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_dat(fifo_rd_dat)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [3:0] id; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  logic [31:0] src_q[$];
  logic [1:0]  bresp_plan[$];
  logic [3:0]  aw_ids[$];
  logic [3:0]  b_pend[$];
  int n_cmp = 0, n_bad = 0;
  logic [3:0] cid_m = '0;
  bit pop_flag = 0, b_fired = 0;
  int w_beats = 0, stall_at = -1, stall_cnt = 0, aw_valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the byte range and emits the expected bursts, beats and responses.
  task automatic plan(input logic [31:0] dst, input logic [31:0] src, input int bnum, input int chunk,
                      input int err_burst, output bit exp_err);
    int c, rem, lo, nbytes, beats, burst;
    logic [31:0] addr, d;
    logic [3:0] strb;
    bit full;
    exp_err = 0;
    if (dst[1:0] != src[1:0]) begin
      exp_err = 1;
      return;
    end
    if (bnum <= DS) c = bnum;
    else if (chunk <= DS) c = DS;
    else c = ((chunk / DS) < 16 ? (chunk / DS) : 16) * DS;
    addr = dst; rem = bnum; burst = 0;
    while (rem > 0) begin
      lo = int'(addr % DS);
      if (lo != 0) begin
        full = (rem >= DS - lo); beats = 1; nbytes = full ? DS - lo : 1;
      end else if (rem >= c) begin
        full = 1; beats = c / DS; nbytes = c;
      end else if (rem >= DS) begin
        full = 1; beats = rem / DS; nbytes = beats * DS;
      end else begin
        full = 0; beats = 1; nbytes = 1;
      end
      strb = full ? 4'((4'hF << lo) & 4'hF) : 4'(1 << lo);
      cid_m = cid_m + 4'd1;
      exp_aw.push_back('{addr, 8'(beats - 1), full ? 3'd2 : 3'd0, cid_m});
      for (int b = 0; b < beats; b++) begin
        d = $urandom;
        src_q.push_back(d);
        exp_w.push_back('{d, strb, b == beats - 1});
      end
      bresp_plan.push_back(burst == err_burst ? 2'b10 : 2'b00);
      if (burst == err_burst) exp_err = 1;
      addr = addr + 32'(nbytes);
      rem = rem - nbytes;
      burst++;
    end
  endtask

  // FIFO source and AXI slave: acts on handshakes the monitor saw at the previous edge.
  always @(posedge ACLK) begin
    #1;
    if (pop_flag) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_flag = 0;
    end
    if (stall_cnt > 0) begin
      fifo_rd_vld = 1'b0;
      stall_cnt--;
    end else begin
      fifo_rd_vld = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
    end
    fifo_rd_dat = {4'($urandom), (src_q.size() > 0) ? src_q[0] : 32'($urandom)};
    M_AWREADY = 1'($urandom_range(0, 1));
    M_WREADY = ($urandom_range(0, 3) != 0);
    if (M_BVALID && b_fired) begin
      M_BVALID = 1'b0;
      b_fired = 0;
    end
    if (!M_BVALID && b_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      M_BVALID = 1'b1;
      M_BID = b_pend.pop_front();
      M_BRESP = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
    end
  end

  // Monitor: compares every AW/W handshake against the scoreboard queues.
  always @(negedge ACLK) begin
    if (ARESETn && DMA_EN) begin
      aw_t ea;
      w_t ew;
      if (M_AWVALID) aw_valid_cycles++;
      if (!fifo_rd_vld && exp_w.size() > 0) check("wvalid_on_empty_fifo", M_WVALID, 1'b0);
      if (M_AWVALID && M_AWREADY) begin
        if (exp_aw.size() == 0) begin
          check("aw_unexpected", M_AWADDR, 64'hDEAD_BEEF_0000_0000);
        end else begin
          ea = exp_aw.pop_front();
          check("awaddr", M_AWADDR, ea.addr);
          check("awlen", M_AWLEN, ea.len);
          check("awsize", M_AWSIZE, ea.size);
          check("awid", M_AWID, ea.id);
          check("awburst", M_AWBURST, 2'b01);
          aw_ids.push_back(ea.id);
        end
      end
      if (M_WVALID && M_WREADY) begin
        check("fifo_pop_with_beat", fifo_rd_rdy, 1'b1);
        check("w_after_aw", aw_ids.size() != 0, 1'b1);
        if (exp_w.size() == 0) begin
          check("w_unexpected", M_WDATA, 64'hDEAD_BEEF_0000_0000);
        end else begin
          ew = exp_w.pop_front();
          check("wdata", M_WDATA, ew.data);
          check("wstrb", M_WSTRB, ew.strb);
          check("wlast", M_WLAST, ew.last);
          if (ew.last && aw_ids.size() > 0) b_pend.push_back(aw_ids.pop_front());
        end
        pop_flag = 1;
        w_beats++;
        if (w_beats == stall_at) stall_cnt = 5;
      end
      if (M_BVALID && M_BREADY) b_fired = 1;
    end
  end

  task automatic run_xfer(input logic [31:0] dst, input logic [31:0] src, input int bnum, input int chunk,
                          input int err_burst, input int stall_beat);
    bit exp_err;
    int t, aw_before;
    plan(dst, src, bnum, chunk, err_burst, exp_err);
    aw_before = aw_valid_cycles;
    @(posedge ACLK); #1;
    DMA_DST = dst; DMA_SRC = src; DMA_BNUM = 16'(bnum); DMA_CHUNK = 8'(chunk);
    w_beats = 0; stall_at = stall_beat; DMA_GO = 1'b1;
    if (dst[1:0] != src[1:0]) begin
      @(posedge ACLK); @(negedge ACLK);
      check("misalign_done", DMA_DONE, 1'b1);
      check("misalign_err", DMA_ERR, 1'b1);
      check("misalign_busy", DMA_BUSY, 1'b0);
      repeat (8) @(negedge ACLK);
      check("misalign_no_awvalid", 64'(aw_valid_cycles), 64'(aw_before));
    end else begin
      t = 0;
      while (!DMA_DONE && t < 4000) begin
        @(negedge ACLK);
        t++;
      end
      check("done", DMA_DONE, 1'b1);
      check("err", DMA_ERR, exp_err);
      check("busy_after_done", DMA_BUSY, 1'b0);
      check("aw_left", 64'(exp_aw.size()), 0);
      check("w_left", 64'(exp_w.size()), 0);
      check("b_left", 64'(bresp_plan.size()), 0);
      repeat (5) @(negedge ACLK);
      check("go_held_no_restart", {DMA_BUSY, DMA_DONE}, 2'b01);
    end
    @(posedge ACLK); #1;
    DMA_GO = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    check("done_cleared", DMA_DONE, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    int t;
    logic [31:0] dst, src;
    repeat (2) @(negedge ACLK);
    check("rst_awvalid_wvalid_bready", {M_AWVALID, M_WVALID, M_WLAST, M_BREADY, fifo_rd_rdy}, 0);
    check("rst_dma_status", {DMA_BUSY, DMA_DONE, DMA_ERR}, 0);
    check("rst_aw_fields", {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE}, 0);
    check("rst_wstrb_wdata", {M_WSTRB, M_WDATA}, 0);
    check("rst_awburst", M_AWBURST, 2'b01);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    run_xfer(32'h1000, 32'h2000, 64, 16, -1, -1);
    run_xfer(32'h1001, 32'h3001, 6, 16, -1, -1);
    run_xfer(32'h0000, 32'h0002, 8, 16, -1, -1);
    run_xfer(32'h4000, 32'h0100, 32, 255, -1, 3);
    run_xfer(32'h5000, 32'h0600, 32, 16, 1, -1);

    plan(32'h8000, 32'h0, 64, 16, -1, e);
    @(posedge ACLK); #1;
    DMA_DST = 32'h8000; DMA_SRC = 32'h0; DMA_BNUM = 16'd64; DMA_CHUNK = 8'd16;
    w_beats = 0; stall_at = -1; DMA_GO = 1'b1;
    t = 0;
    while (!M_WVALID && t < 400) begin
      @(negedge ACLK);
      t++;
    end
    check("en_reached_w", M_WVALID, 1'b1);
    @(posedge ACLK); #1;
    DMA_EN = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    check("en_clear_handshakes", {M_AWVALID, M_WVALID, M_WLAST, M_BREADY, fifo_rd_rdy}, 0);
    check("en_clear_status", {DMA_BUSY, DMA_DONE, DMA_ERR}, 0);
    check("en_clear_aw", {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE}, 0);
    check("en_clear_w", {M_WSTRB, M_WDATA}, 0);
    check("en_clear_awburst", M_AWBURST, 2'b01);
    exp_aw.delete(); exp_w.delete(); src_q.delete(); bresp_plan.delete();
    aw_ids.delete(); b_pend.delete();
    M_BVALID = 1'b0; pop_flag = 0; b_fired = 0; cid_m = '0; stall_cnt = 0;
    @(posedge ACLK); #1;
    DMA_GO = 1'b0;
    @(posedge ACLK); #1;
    DMA_EN = 1'b1;
    run_xfer(32'h9000, 32'h0, 40, 32, -1, -1);

    for (int i = 0; i < 24; i++) begin
      dst = $urandom;
      if ($urandom_range(0, 5) == 0) dst = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
      src = {30'($urandom), dst[1:0]};
      if ($urandom_range(0, 7) == 0) src[1:0] = dst[1:0] ^ 2'($urandom_range(1, 3));
      run_xfer(dst, src, $urandom_range(4, 160), $urandom_range(0, 255),
               ($urandom_range(0, 4) == 0) ? 0 : -1,
               ($urandom_range(0, 3) == 0) ? 2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
